mem_controller: RTL and testbench
=================================

// Module: mem_controller
// PURPOSE
//  Arbitrates load/store requests from NUM_CONSUMERS per-thread LSUs onto one external memory port.
//  Sits directly downstream of the LSUs: takes their valid/address(/data) requests and returns ready(/data).
//  Grants one consumer at a time in round-robin order and holds each consumer's ready until that consumer drops valid.
// PARAMETERS
//  NUM_CONSUMERS  4  number of LSU request ports, >=2
//  ADDR_BITS      8  memory address width
//  DATA_BITS      8  memory data width
// PORTS
//  clk                     in   1                  rising-edge clock
//  reset                   in   1                  asynchronous, active-high; clears all state
//  consumer_read_valid     in   NUM_CONSUMERS      per-consumer read request, held until ready seen
//  consumer_read_address   in   NUM_CONSUMERS*ADDR_BITS  packed, consumer i at [i*ADDR_BITS +: ADDR_BITS]
//  consumer_read_ready     out  NUM_CONSUMERS      read complete; read data valid
//  consumer_read_data      out  NUM_CONSUMERS*DATA_BITS  packed return data, held until next read for that consumer
//  consumer_write_valid    in   NUM_CONSUMERS      per-consumer write request
//  consumer_write_address  in   NUM_CONSUMERS*ADDR_BITS  packed
//  consumer_write_data     in   NUM_CONSUMERS*DATA_BITS  packed
//  consumer_write_ready    out  NUM_CONSUMERS      write accepted by memory
//  mem_read_valid          out  1                  read request to memory
//  mem_read_address        out  ADDR_BITS
//  mem_read_ready          in   1                  memory read done; mem_read_data valid this cycle
//  mem_read_data           in   DATA_BITS
//  mem_write_valid         out  1                  write request to memory
//  mem_write_address       out  ADDR_BITS
//  mem_write_data          out  DATA_BITS
//  mem_write_ready         in   1                  memory write done
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transaction): all outputs 0, state IDLE, rr pointer 0, grant cleared.
//    An outstanding memory transaction is abandoned; no ready is returned to the consumer.
//  - States: IDLE, READ_WAIT, WRITE_WAIT, RELAY. All outputs registered.
//  - IDLE: scan consumers from ptr, ptr+1, ... wrapping mod NUM_CONSUMERS; first consumer c with read_valid
//    or write_valid is granted. Read wins over write if both set on same c. At that edge: latch address
//    (and write data) onto mem_* and set mem_read_valid or mem_write_valid -> READ_WAIT / WRITE_WAIT.
//    No request: stay IDLE, outputs unchanged.
//  - READ_WAIT: on edge with mem_read_ready=1: mem_read_valid<=0, consumer_read_data[c]<=mem_read_data,
//    consumer_read_ready[c]<=1 -> RELAY. Else hold (mem_* stable, no timeout).
//  - WRITE_WAIT: on edge with mem_write_ready=1: mem_write_valid<=0, consumer_write_ready[c]<=1 -> RELAY.
//  - RELAY: hold ready[c] while consumer c's corresponding valid stays 1. On edge with that valid=0:
//    ready[c]<=0, ptr<=(c+1) mod NUM_CONSUMERS -> IDLE. Prevents re-issue of a request the LSU still holds.
//  - Latency: request visible at edge k -> mem valid high after k; mem ready at edge j -> consumer ready high
//    after j; consumer valid low at edge m -> ready low after m; next grant earliest at edge m+1.
//  - Only one consumer ready bit is ever high; at most one of mem_read_valid/mem_write_valid is high.
//  - Consumer changes on inputs while granted are ignored (address/data latched at grant).
//  - ptr wrap: NUM_CONSUMERS-1 -> 0. Non-granted requests stay pending, not dropped.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE=0, READ_WAIT=1, WRITE_WAIT=2, RELAY=3) alongside
//    existing LSU state codes; ADDR_BITS/DATA_BITS defaults.
//  - Sub-module rr_arbiter: combinational pick of first requester at/after ptr; outputs grant index + found.
//  - Top: FSM, grant register, ptr register, packed-vector slicing, output registers.
// TESTING
//  1 Reset: assert reset mid-READ_WAIT -> all outputs 0 immediately, state IDLE; release, no stale ready.
//  2 Single read: c0 read_valid, addr 0x12; mem ready 3 cycles later with data 0xA5 -> mem_read_address=0x12,
//    read_ready[0]=1, read_data[0]=0xA5; held until c0 drops valid, then ready 0 next edge.
//  3 Single write: c2 write addr 0x40 data 0x7E -> mem_write_valid=1, addr 0x40, data 0x7E; mem_write_ready
//    -> write_ready[2]=1 until valid drops.
//  4 Round-robin: all 4 consumers read at once -> grants in order 0,1,2,3, then c0 again if still requesting;
//    with ptr=3 and requests on 1,3 -> 3 served before 1.
//  5 Read+write same consumer: c1 both valid -> read served first, write on next grant cycle.
//  6 Held valid: consumer keeps read_valid high 5 cycles after ready -> no second mem_read_valid issued;
//    assertion checks onehot0(ready), mutually exclusive mem valids, mem_* stable while waiting.

Source files
------------

// File: rtl/mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_controller_pkg
// Brief  : Shared widths, LSU/controller state encodings and index helper.
// Rev    : 1.0  initial release
// ============================================================================
package mem_controller_pkg;

    localparam int DEFAULT_NUM_CONSUMERS = 4;
    localparam int DEFAULT_ADDR_BITS     = 8;
    localparam int DEFAULT_DATA_BITS     = 8;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    localparam logic [1:0] CTRL_IDLE       = 2'd0;
    localparam logic [1:0] CTRL_READ_WAIT  = 2'd1;
    localparam logic [1:0] CTRL_WRITE_WAIT = 2'd2;
    localparam logic [1:0] CTRL_RELAY      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = CTRL_IDLE,
        ST_READ_WAIT  = CTRL_READ_WAIT,
        ST_WRITE_WAIT = CTRL_WRITE_WAIT,
        ST_RELAY      = CTRL_RELAY
    } ctrl_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module : mem_controller_if
// Brief  : LSU-facing and memory-facing buses of the memory controller.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_controller_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) ();
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    // Controller view: serves the LSUs, drives the memory port.
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational pick of the first requester at or after ptr (wrapping).
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = 2
) (
    input  wire logic [NUM_REQ-1:0]  req,
    input  wire logic [IDX_BITS-1:0] ptr,
    output logic      [IDX_BITS-1:0] grant,
    output logic                     found
);
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = IDX_BITS'(idx);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module : mem_controller
// Brief  : Round-robin arbitration of per-thread LSU loads/stores onto one
//          external memory port; ready is held until the LSU drops valid.
// Rev    : 1.0  initial release
// ============================================================================
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = DEFAULT_NUM_CONSUMERS,
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS
) (
    input wire logic clk,
    input wire logic reset,
    mem_controller_if.slave bus
);
    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    ctrl_state_t                        r_state, w_state_next;
    logic [IDX_BITS-1:0]                r_grant, w_grant_next;
    logic [IDX_BITS-1:0]                r_ptr, w_ptr_next;
    logic                               r_is_read, w_is_read_next;
    logic                               r_mem_read_valid, w_mem_read_valid_next;
    logic [ADDR_BITS-1:0]               r_mem_read_address, w_mem_read_address_next;
    logic                               r_mem_write_valid, w_mem_write_valid_next;
    logic [ADDR_BITS-1:0]               r_mem_write_address, w_mem_write_address_next;
    logic [DATA_BITS-1:0]               r_mem_write_data, w_mem_write_data_next;
    logic [NUM_CONSUMERS-1:0]           r_read_ready, w_read_ready_next;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data, w_read_data_next;
    logic [NUM_CONSUMERS-1:0]           r_write_ready, w_write_ready_next;

    logic [NUM_CONSUMERS-1:0] w_req;
    logic [IDX_BITS-1:0]      w_arb_idx;
    logic                     w_arb_found;
    logic                     w_relay_hold;

    assign w_req = bus.consumer_read_valid | bus.consumer_write_valid;

    rr_arbiter #(
        .NUM_REQ  (NUM_CONSUMERS),
        .IDX_BITS (IDX_BITS)
    ) u_arbiter (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_arb_idx),
        .found (w_arb_found)
    );

    always_comb begin
        w_state_next             = r_state;
        w_grant_next             = r_grant;
        w_ptr_next               = r_ptr;
        w_is_read_next           = r_is_read;
        w_mem_read_valid_next    = r_mem_read_valid;
        w_mem_read_address_next  = r_mem_read_address;
        w_mem_write_valid_next   = r_mem_write_valid;
        w_mem_write_address_next = r_mem_write_address;
        w_mem_write_data_next    = r_mem_write_data;
        w_read_ready_next        = r_read_ready;
        w_read_data_next         = r_read_data;
        w_write_ready_next       = r_write_ready;
        w_relay_hold             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_grant_next = w_arb_idx;
                    // A consumer asserting both kinds is served read first.
                    if (bus.consumer_read_valid[w_arb_idx]) begin
                        w_is_read_next          = 1'b1;
                        w_mem_read_valid_next   = 1'b1;
                        w_mem_read_address_next =
                            bus.consumer_read_address[int'(w_arb_idx)*ADDR_BITS +: ADDR_BITS];
                        w_state_next            = ST_READ_WAIT;
                    end else begin
                        w_is_read_next           = 1'b0;
                        w_mem_write_valid_next   = 1'b1;
                        w_mem_write_address_next =
                            bus.consumer_write_address[int'(w_arb_idx)*ADDR_BITS +: ADDR_BITS];
                        w_mem_write_data_next    =
                            bus.consumer_write_data[int'(w_arb_idx)*DATA_BITS +: DATA_BITS];
                        w_state_next             = ST_WRITE_WAIT;
                    end
                end
            end
            ST_READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    w_mem_read_valid_next = 1'b0;
                    w_read_data_next[int'(r_grant)*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
                    w_read_ready_next          = '0;
                    w_read_ready_next[r_grant] = 1'b1;
                    w_state_next               = ST_RELAY;
                end
            end
            ST_WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    w_mem_write_valid_next      = 1'b0;
                    w_write_ready_next          = '0;
                    w_write_ready_next[r_grant] = 1'b1;
                    w_state_next                = ST_RELAY;
                end
            end
            ST_RELAY: begin
                // Waiting for the LSU to let go stops a still-held request being re-issued.
                w_relay_hold = r_is_read ? bus.consumer_read_valid[r_grant]
                                         : bus.consumer_write_valid[r_grant];
                if (!w_relay_hold) begin
                    w_read_ready_next  = '0;
                    w_write_ready_next = '0;
                    w_ptr_next   = IDX_BITS'(wrap_inc(int'(r_grant), NUM_CONSUMERS));
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_grant             <= '0;
            r_ptr               <= '0;
            r_is_read           <= 1'b0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_read_ready        <= '0;
            r_read_data         <= '0;
            r_write_ready       <= '0;
        end else begin
            r_state             <= w_state_next;
            r_grant             <= w_grant_next;
            r_ptr               <= w_ptr_next;
            r_is_read           <= w_is_read_next;
            r_mem_read_valid    <= w_mem_read_valid_next;
            r_mem_read_address  <= w_mem_read_address_next;
            r_mem_write_valid   <= w_mem_write_valid_next;
            r_mem_write_address <= w_mem_write_address_next;
            r_mem_write_data    <= w_mem_write_data_next;
            r_read_ready        <= w_read_ready_next;
            r_read_data         <= w_read_data_next;
            r_write_ready       <= w_write_ready_next;
        end
    end

    assign bus.consumer_read_ready  = r_read_ready;
    assign bus.consumer_read_data   = r_read_data;
    assign bus.consumer_write_ready = r_write_ready;
    assign bus.mem_read_valid       = r_mem_read_valid;
    assign bus.mem_read_address     = r_mem_read_address;
    assign bus.mem_write_valid      = r_mem_write_valid;
    assign bus.mem_write_address    = r_mem_write_address;
    assign bus.mem_write_data       = r_mem_write_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_controller
// Brief  : Self-checking bench: memory model, mem-side scoreboard, vector table.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_controller;
    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;

    mem_controller_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_read;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
    } sb_t;

    typedef struct {
        int            c;
        bit            is_read;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
        logic [DB-1:0] exp_rd;
        int            delay;
        int            hold;
    } vec_t;

    sb_t           sb [$];
    int            order [$];
    vec_t          vecs [6];
    logic [DB-1:0] exp_rd [N];
    logic [DB-1:0] mem [256];
    int            checks = 0;
    int            errors = 0;
    int            rd_delay = 0;
    int            wr_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_ready"},  32'(bus.consumer_read_ready), 0);
        check({tag, "_write_ready"}, 32'(bus.consumer_write_ready), 0);
        check({tag, "_read_data"},   32'(bus.consumer_read_data), 0);
        check({tag, "_mem_rv"},      32'(bus.mem_read_valid), 0);
        check({tag, "_mem_ra"},      32'(bus.mem_read_address), 0);
        check({tag, "_mem_wv"},      32'(bus.mem_write_valid), 0);
        check({tag, "_mem_wa"},      32'(bus.mem_write_address), 0);
        check({tag, "_mem_wd"},      32'(bus.mem_write_data), 0);
    endtask

    // Memory model: answers a pending request after rd_delay/wr_delay cycles.
    initial begin
        int rc, wc;
        rc = 0;
        wc = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hC3;
        mem[8'h12] = 8'hA5;
        bus.mem_read_ready  = 1'b0;
        bus.mem_read_data   = '0;
        bus.mem_write_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_read_ready  = 1'b0;
            bus.mem_write_ready = 1'b0;
            bus.mem_read_data   = 8'($urandom);
            if (bus.mem_read_valid) begin
                if (rc >= rd_delay) begin
                    bus.mem_read_ready = 1'b1;
                    bus.mem_read_data  = mem[bus.mem_read_address];
                    rc = 0;
                end else rc++;
            end else rc = 0;
            if (bus.mem_write_valid) begin
                if (wc >= wr_delay) begin
                    bus.mem_write_ready = 1'b1;
                    mem[bus.mem_write_address] = bus.mem_write_data;
                    wc = 0;
                end else wc++;
            end else wc = 0;
        end
    end

    // Mem-side monitor: pops the scoreboard on every newly issued request.
    logic          prev_rv, prev_wv;
    logic [AB-1:0] prev_ra, prev_wa;
    logic [DB-1:0] prev_wd;
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            prev_rv = 1'b0;
            prev_wv = 1'b0;
        end else begin
            check("ready_onehot0", 32'($onehot0({bus.consumer_read_ready, bus.consumer_write_ready})), 1);
            check("mem_valid_excl", 32'(bus.mem_read_valid & bus.mem_write_valid), 0);
            if (bus.mem_read_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    check("unexpected_mem_read", 32'(bus.mem_read_address), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_read", 1, 32'(e.is_read));
                    check("sb_read_addr", 32'(bus.mem_read_address), 32'(e.addr));
                end
            end
            if (bus.mem_read_valid && prev_rv)
                check("mem_ra_stable", 32'(bus.mem_read_address), 32'(prev_ra));
            if (bus.mem_write_valid && !prev_wv) begin
                if (sb.size() == 0) begin
                    check("unexpected_mem_write", 32'(bus.mem_write_address), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_write", 0, 32'(e.is_read));
                    check("sb_write_addr", 32'(bus.mem_write_address), 32'(e.addr));
                    check("sb_write_data", 32'(bus.mem_write_data), 32'(e.wdata));
                end
            end
            if (bus.mem_write_valid && prev_wv) begin
                check("mem_wa_stable", 32'(bus.mem_write_address), 32'(prev_wa));
                check("mem_wd_stable", 32'(bus.mem_write_data), 32'(prev_wd));
            end
            prev_rv = bus.mem_read_valid;
            prev_wv = bus.mem_write_valid;
            prev_ra = bus.mem_read_address;
            prev_wa = bus.mem_write_address;
            prev_wd = bus.mem_write_data;
        end
    end

    task automatic do_txn(input vec_t v);
        int lat;
        bit seen;
        @(negedge clk);
        rd_delay = v.delay;
        wr_delay = v.delay;
        sb.push_back('{v.is_read, v.addr, v.wdata});
        if (v.is_read) begin
            bus.consumer_read_address[v.c*AB +: AB] = v.addr;
            bus.consumer_read_valid[v.c] = 1'b1;
        end else begin
            bus.consumer_write_address[v.c*AB +: AB] = v.addr;
            bus.consumer_write_data[v.c*DB +: DB]    = v.wdata;
            bus.consumer_write_valid[v.c] = 1'b1;
        end
        @(negedge clk);
        check("mem_valid_latency", 32'(v.is_read ? bus.mem_read_valid : bus.mem_write_valid), 1);
        // Changing the inputs after the grant must not disturb the transaction.
        bus.consumer_read_address[v.c*AB +: AB]  = ~v.addr;
        bus.consumer_write_address[v.c*AB +: AB] = ~v.addr;
        bus.consumer_write_data[v.c*DB +: DB]    = ~v.wdata;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            seen = v.is_read ? bus.consumer_read_ready[v.c] : bus.consumer_write_ready[v.c];
            if (!seen) begin
                @(negedge clk);
                lat++;
            end
        end
        check("ready_latency", 32'(lat), 32'(v.delay + 2));
        if (v.is_read) check("read_data", 32'(bus.consumer_read_data[v.c*DB +: DB]), 32'(v.exp_rd));
        check("mem_valid_dropped", 32'(bus.mem_read_valid | bus.mem_write_valid), 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("ready_held", 32'(v.is_read ? bus.consumer_read_ready[v.c] : bus.consumer_write_ready[v.c]), 1);
            check("no_reissue", 32'(bus.mem_read_valid | bus.mem_write_valid), 0);
        end
        bus.consumer_read_valid[v.c]  = 1'b0;
        bus.consumer_write_valid[v.c] = 1'b0;
        @(negedge clk);
        check("ready_release", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
    endtask

    task automatic raise_read(input int c, input logic [AB-1:0] addr);
        bus.consumer_read_address[c*AB +: AB] = addr;
        exp_rd[c] = mem[addr];
        sb.push_back('{1'b1, addr, '0});
        bus.consumer_read_valid[c] = 1'b1;
    endtask

    // LSU side for concurrent requests: drop valid when ready seen, record order.
    task automatic serve(input bit reraise0, input int budget);
        bit pending0, done;
        int cyc;
        pending0 = 1'b0;
        done     = 1'b0;
        cyc      = 0;
        order.delete();
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pending0) begin
                pending0 = 1'b0;
                raise_read(0, 8'h50);
            end
            for (int c = 0; c < N; c++) begin
                if (bus.consumer_read_valid[c] && bus.consumer_read_ready[c]) begin
                    check("serve_read_data", 32'(bus.consumer_read_data[c*DB +: DB]), 32'(exp_rd[c]));
                    bus.consumer_read_valid[c] = 1'b0;
                    order.push_back(c);
                    if (c == 0 && reraise0) begin
                        reraise0 = 1'b0;
                        pending0 = 1'b1;
                    end
                end else if (bus.consumer_write_valid[c] && bus.consumer_write_ready[c]) begin
                    bus.consumer_write_valid[c] = 1'b0;
                    order.push_back(c);
                end
            end
            done = (bus.consumer_read_valid == '0) && (bus.consumer_write_valid == '0) && !pending0;
        end
        check("serve_timeout", 32'(done), 1);
        @(negedge clk);
        check("serve_ready_clear", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
    endtask

    task automatic check_order(input string name, input int exp[$]);
        check({name, "_len"}, 32'(order.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < order.size(); i++)
            check(name, 32'(order[i]), 32'(exp[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 8'h12, 8'h00, 8'hA5, 3, 2};
        vecs[1] = '{2, 1'b0, 8'h40, 8'h7E, 8'h00, 2, 1};
        vecs[2] = '{3, 1'b1, 8'h40, 8'h00, 8'h7E, 0, 0};
        vecs[3] = '{1, 1'b0, 8'hFF, 8'h5C, 8'h00, 0, 0};
        vecs[4] = '{1, 1'b1, 8'hFF, 8'h00, 8'h5C, 1, 5};
        vecs[5] = '{0, 1'b1, 8'h00, 8'h00, 8'hC3, 2, 0};

        reset = 1'b1;
        bus.consumer_read_valid    = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Asynchronous reset in the middle of a read wait.
        @(negedge clk);
        rd_delay = 30;
        sb.push_back('{1'b1, 8'h77, 8'h00});
        bus.consumer_read_address[1*AB +: AB] = 8'h77;
        bus.consumer_read_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pre_mem_rv", 32'(bus.mem_read_valid), 1);
        check("rst_pre_data", 32'(bus.consumer_read_data[0 +: DB]), 32'h C3);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        bus.consumer_read_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_delay = 1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
            check("post_rst_idle", 32'(bus.mem_read_valid | bus.mem_write_valid), 0);
        end

        // Round robin from ptr 0, then c0 re-requests and is served last.
        @(negedge clk);
        for (int c = 0; c < N; c++) raise_read(c, 8'(8'h30 + c));
        serve(1'b1, 200);
        check_order("rr_order", '{0, 1, 2, 3, 0});

        // Move ptr to 3, then 3 must beat 1.
        @(negedge clk);
        raise_read(2, 8'h62);
        serve(1'b0, 100);
        @(negedge clk);
        raise_read(3, 8'h23);
        raise_read(1, 8'h21);
        serve(1'b0, 100);
        check_order("rr_wrap_order", '{3, 1});

        // Read and write from the same consumer: read first.
        @(negedge clk);
        raise_read(1, 8'h44);
        bus.consumer_write_address[1*AB +: AB] = 8'h45;
        bus.consumer_write_data[1*DB +: DB]    = 8'h9A;
        sb.push_back('{1'b0, 8'h45, 8'h9A});
        bus.consumer_write_valid[1] = 1'b1;
        serve(1'b0, 100);
        check_order("rw_order", '{1, 1});
        do_txn('{0, 1'b1, 8'h45, 8'h00, 8'h9A, 0, 0});

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
